// File: rtl/regfile_pkg.sv
// regfile_pkg: shared copy-FSM state type and default parameter constants for regfile_banked
package regfile_pkg;
  typedef enum logic [1:0] {IDLE, SAVE, RESTORE} copy_state_e;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_MAIN_IDX = 1;
  localparam int DEF_ZERO_REG = 0;
  localparam int DEF_BYPASS = 1;
endpackage

// File: rtl/rf_copy_ctrl.sv
// rf_copy_ctrl: sequences a whole-bank copy (SAVE active->shadow, RESTORE shadow->active), one register per cycle
// ports: clk, reset (async, active-high); save/restore requests in; state, idx (entry being copied), busy, done (1-cycle pulse) out
module rf_copy_ctrl
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              save,
  input  logic              restore,
  output copy_state_e       state,
  output logic [ADDR_W-1:0] idx,
  output logic              busy,
  output logic              done
);
  copy_state_e       state_q;
  logic [ADDR_W-1:0] idx_q;
  logic              busy_q, done_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (save || restore) begin
          state_q <= save ? SAVE : RESTORE;
          idx_q   <= '0;
          busy_q  <= 1'b1;
        end
      end else begin
        idx_q <= idx_q + 1'b1;
        if (idx_q == '1) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
      end
    end
  end
  assign state = state_q;
  assign idx   = idx_q;
  assign busy  = busy_q;
  assign done  = done_q;
endmodule

// File: rtl/regfile_banked.sv
// regfile_banked: 2-read/1-write register file with a shadow bank and serial save/restore copy
// ports: clk, reset (async, active-high); r1/r2 -> r1out/r2out read ports; wDest/wDat/regWrt write port;
//        m = active[MAIN_IDX]; save/restore copy requests; busy/done copy status
module regfile_banked
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int MAIN_IDX = DEF_MAIN_IDX,
  parameter int ZERO_REG = DEF_ZERO_REG,
  parameter int BYPASS   = DEF_BYPASS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] r1,
  input  logic [ADDR_W-1:0] r2,
  output logic [DATA_W-1:0] r1out,
  output logic [DATA_W-1:0] r2out,
  input  logic [ADDR_W-1:0] wDest,
  input  logic [DATA_W-1:0] wDat,
  input  logic              regWrt,
  output logic [DATA_W-1:0] m,
  input  logic              save,
  input  logic              restore,
  output logic              busy,
  output logic              done
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] MAIN_A = ADDR_W'(MAIN_IDX);
  localparam bit ZR = ZERO_REG != 0;
  localparam bit BP = BYPASS != 0;
  copy_state_e       state;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] active_q [DEPTH];
  logic [DATA_W-1:0] active_d [DEPTH];
  logic [DATA_W-1:0] shadow_q [DEPTH];
  logic [DATA_W-1:0] shadow_d [DEPTH];
  logic              wr_en;
  rf_copy_ctrl #(.ADDR_W(ADDR_W)) u_ctrl (
    .clk     (clk),
    .reset   (reset),
    .save    (save),
    .restore (restore),
    .state   (state),
    .idx     (idx),
    .busy    (busy),
    .done    (done)
  );
  // writes are dropped while a copy owns the banks, and register 0 is read-only when hardwired
  assign wr_en = regWrt && !busy && !(ZR && wDest == '0);
  always_comb begin
    active_d = active_q;
    shadow_d = shadow_q;
    if (wr_en) active_d[wDest] = wDat;
    if (state == SAVE) shadow_d[idx] = active_q[idx];
    if (state == RESTORE) active_d[idx] = shadow_q[idx];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= '{default: '0};
      shadow_q <= '{default: '0};
    end else begin
      active_q <= active_d;
      shadow_q <= shadow_d;
    end
  end
  // wr_en already excludes register 0 when hardwired, so bypass never leaks a value there
  assign r1out = (ZR && r1 == '0) ? '0 : (BP && wr_en && r1 == wDest) ? wDat : active_q[r1];
  assign r2out = (ZR && r2 == '0) ? '0 : (BP && wr_en && r2 == wDest) ? wDat : active_q[r2];
  assign m     = (ZR && MAIN_A == '0) ? '0 : active_q[MAIN_A];
endmodule

// File: tb/tb_regfile_banked.sv
// tb_regfile_banked: scoreboard bench for regfile_banked (default instance plus a ZERO_REG=1 instance)
module tb_regfile_banked;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  r1 = '0, r2 = '0, wDest = '0;
  logic [15:0] wDat = '0;
  logic        regWrt = 1'b0, save = 1'b0, restore = 1'b0;
  logic [15:0] r1out, r2out, m, z_r1out, z_r2out, z_m;
  logic        busy, done, z_busy, z_done;
  int          n_tests = 0;
  int          n_fail = 0;
  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];
  regfile_banked dut (
    .clk(clk), .reset(reset), .r1(r1), .r2(r2), .r1out(r1out), .r2out(r2out),
    .wDest(wDest), .wDat(wDat), .regWrt(regWrt), .m(m),
    .save(save), .restore(restore), .busy(busy), .done(done)
  );
  regfile_banked #(.ZERO_REG(1)) dut_z (
    .clk(clk), .reset(reset), .r1(r1), .r2(r2), .r1out(z_r1out), .r2out(z_r2out),
    .wDest(wDest), .wDat(wDat), .regWrt(regWrt), .m(z_m),
    .save(save), .restore(restore), .busy(z_busy), .done(z_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask
  task automatic pop(input logic [31:0] got);
    exp_t e;
    if (sb.size() == 0) chk("sb_underflow", 1, 0);
    else begin
      e = sb.pop_front();
      chk(e.tag, got, e.exp);
    end
  endtask
  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    regWrt = 1'b1;
    wDest = a;
    wDat = d;
    @(negedge clk);
    regWrt = 1'b0;
  endtask
  task automatic pulse(input logic s, input logic r);
    @(negedge clk);
    save = s;
    restore = r;
    @(negedge clk);
    save = 1'b0;
    restore = 1'b0;
  endtask
  // called right after the request edge; counts busy and done samples over a bounded window
  task automatic copy_watch(output int nb, output int nd);
    nb = 0;
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (busy) nb++;
      if (done) nd++;
      @(negedge clk);
    end
  endtask
  task automatic read_chk(input string tag, input logic [2:0] a, input logic [15:0] exp);
    r1 = a;
    #1;
    push(tag, exp);
    pop(r1out);
  endtask
  initial begin
    int nb, nd, seen;
    #2;
    push("rst_r1out", 0); pop(r1out);
    push("rst_r2out", 0); pop(r2out);
    push("rst_m", 0);     pop(m);
    push("rst_busy", 0);  pop(busy);
    push("rst_done", 0);  pop(done);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i < 8; i++) wr(3'(i), 16'(i));
    @(negedge clk);
    r1 = 0; r2 = 7; #1;
    push("rd_r1_0", 0); pop(r1out);
    push("rd_r2_7", 7); pop(r2out);
    r1 = 3; r2 = 4; #1;
    push("rd_r1_3", 3); pop(r1out);
    push("rd_r2_4", 4); pop(r2out);
    push("m_is_1", 1);  pop(m);
    @(negedge clk);
    regWrt = 1'b0; wDat = 16'd10; wDest = 3'd1;
    @(negedge clk);
    read_chk("nowrite_r1", 3'd1, 16'd1);
    regWrt = 1'b1; wDat = 16'h0055; wDest = 3'd2; r1 = 3'd2; r2 = 3'd2; #1;
    push("bypass_r1", 16'h55); pop(r1out);
    push("bypass_r2", 16'h55); pop(r2out);
    @(negedge clk);
    regWrt = 1'b0;
    read_chk("wr_r2_kept", 3'd2, 16'h55);
    wr(3'd2, 16'd2);
    pulse(1'b1, 1'b0);
    copy_watch(nb, nd);
    push("save_busy_cycles", 8); pop(nb);
    push("save_done_pulses", 1); pop(nd);
    for (int i = 1; i < 8; i++) wr(3'(i), 16'(10 * i));
    @(negedge clk);
    read_chk("new_r7", 3'd7, 16'd70);
    pulse(1'b0, 1'b1);
    copy_watch(nb, nd);
    push("rest_busy_cycles", 8); pop(nb);
    push("rest_done_pulses", 1); pop(nd);
    for (int i = 1; i < 8; i++) read_chk($sformatf("restored_r%0d", i), 3'(i), 16'(i));
    push("restored_m", 1); pop(m);
    pulse(1'b1, 1'b0);
    regWrt = 1'b1; wDest = 3'd5; wDat = 16'hAAAA;
    read_chk("busy_no_bypass", 3'd5, 16'd5);
    @(negedge clk);
    @(negedge clk);
    regWrt = 1'b0;
    for (int k = 0; k < 12 && busy; k++) @(negedge clk);
    push("save2_ends", 0); pop(busy);
    read_chk("busy_write_dropped", 3'd5, 16'd5);
    pulse(1'b0, 1'b1);
    save = 1'b1;
    @(negedge clk);
    @(negedge clk);
    save = 1'b0;
    seen = 0;
    for (int k = 0; k < 12 && seen == 0; k++) begin
      #1;
      if (done) seen = 1;
      else @(negedge clk);
    end
    push("restore2_done", 1); pop(seen);
    @(negedge clk);
    #1;
    push("save_ignored_1", 0); pop(busy);
    @(negedge clk);
    #1;
    push("save_ignored_2", 0); pop(busy);
    read_chk("restore2_r5", 3'd5, 16'd5);
    pulse(1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    r1 = 3'd7; r2 = 3'd3;
    reset = 1'b1;
    #1;
    push("midrst_r1out", 0); pop(r1out);
    push("midrst_r2out", 0); pop(r2out);
    push("midrst_m", 0);     pop(m);
    push("midrst_busy", 0);  pop(busy);
    push("midrst_done", 0);  pop(done);
    @(negedge clk);
    reset = 1'b0;
    copy_watch(nb, nd);
    push("midrst_no_done", 0); pop(nd);
    push("midrst_no_busy", 0); pop(nb);
    @(negedge clk);
    regWrt = 1'b1; wDest = 3'd0; wDat = 16'hFFFF; r1 = 3'd0; r2 = 3'd0; #1;
    push("zr_bypass_r1", 0);     pop(z_r1out);
    push("nz_bypass_r2", 16'hFFFF); pop(r2out);
    @(negedge clk);
    regWrt = 1'b0;
    #1;
    push("zr_r0_after", 0);      pop(z_r1out);
    push("nz_r0_after", 16'hFFFF); pop(r1out);
    wr(3'd3, 16'd33);
    pulse(1'b1, 1'b1);
    copy_watch(nb, nd);
    push("both_busy_cycles", 8); pop(z_busy ? 99 : nb);
    r1 = 3'd3; #1;
    push("both_r3_kept", 33); pop(z_r1out);
    wr(3'd3, 16'd44);
    pulse(1'b0, 1'b1);
    copy_watch(nb, nd);
    r1 = 3'd3; #1;
    push("both_took_save", 33); pop(z_r1out);
    push("both_took_save_nz", 33); pop(r1out);
    if (sb.size() != 0) chk("sb_leftover", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/regfile_banked.md
REGFILE_BANKED -- requirements
Module: regfile_banked

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3, address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter MAIN_IDX, default 1, index of the register driven on m.
REQ-004 SHALL have parameter ZERO_REG, default 0; when 1, register 0 reads as zero and ignores writes.
REQ-005 SHALL have parameter BYPASS, default 1; when 1, reads see same-cycle write data.
REQ-006 SHALL have port clk, input, 1, single system clock; all state changes on the rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-008 SHALL have ports r1 and r2, input, ADDR_W each, read addresses.
REQ-009 SHALL have ports r1out and r2out, output, DATA_W each, read data.
REQ-010 SHALL have ports wDest (input, ADDR_W), wDat (input, DATA_W) and regWrt (input, 1): write address, write data and write enable.
REQ-011 SHALL have port m, output, DATA_W, equal to active[MAIN_IDX].
REQ-012 SHALL have ports save and restore, input, 1 each, bank-copy requests, sampled on clk.
REQ-013 SHALL have ports busy and done, output, 1 each: copy in progress, and a 1-cycle completion pulse.

Function
REQ-014 SHALL hold two arrays of DEPTH x DATA_W registers: active and shadow.
REQ-015 SHALL write wDat to active[wDest] on a clk edge when regWrt=1 and busy=0.
REQ-016 SHALL drop regWrt while busy=1, with no effect on either array.
REQ-017 SHALL drive r1out, r2out and m combinationally from active.
REQ-018 SHALL, with BYPASS=1, return wDat on r1out/r2out when regWrt=1, busy=0 and the read address equals wDest.
REQ-019 SHALL, with ZERO_REG=1, read address 0 as 0 on every output (bypass included) and ignore writes to address 0.
REQ-020 SHALL implement FSM states IDLE, SAVE and RESTORE.
REQ-021 SHALL, in IDLE, go to SAVE with idx=0 on save=1; on restore=1 (save=0) go to RESTORE with idx=0; if both are 1, save wins.
REQ-022 SHALL, each edge in SAVE, copy shadow[idx] <= active[idx]; each edge in RESTORE, copy active[idx] <= shadow[idx]; then idx++.
REQ-023 SHALL, on the edge where idx=DEPTH-1, return to IDLE and set done=1 for exactly one cycle.
REQ-024 SHALL hold busy=1 in exactly DEPTH consecutive cycles per copy (busy = state!=IDLE).
REQ-025 SHALL ignore save/restore while busy; requests are not queued.
REQ-026 SHALL wrap idx modulo DEPTH with no out-of-range access.
REQ-027 SHALL serve reads from active during a copy; reads during RESTORE show a partially restored bank.

Reset
REQ-028 SHALL, on reset=1, immediately clear every active and shadow entry to 0 and set state=IDLE, idx=0, busy=0, done=0; r1out, r2out and m read 0.
REQ-029 SHALL, on reset mid-copy, abort the copy with no done pulse.

Structure
REQ-030 SHALL place the FSM state enum and the default parameter constants in shared package regfile_pkg.
REQ-031 SHALL implement the FSM and idx counter in sub-module rf_copy_ctrl (inputs save, restore; outputs state, idx, busy, done); storage and read muxes stay in regfile_banked.

Verification
REQ-032 SHALL cover: reset, then write 1..7 to regs 1..7 -> r1=0,r2=7 reads 0,7; r1=3,r2=4 reads 3,4; m=1.
REQ-033 SHALL cover: regWrt=0, wDat=10, wDest=1 -> reg 1 stays 1; regWrt=1, wDat=0x55, wDest=r1=2 same cycle -> r1out=0x55 before the edge (BYPASS=1).
REQ-034 SHALL cover: save pulse, then regs 1..7 written 10..70, then restore pulse -> busy high 8 cycles per copy, one done pulse each, then regs read 1..7 again.
REQ-035 SHALL cover: regWrt=1, wDat=0xAAAA, wDest=5 during SAVE -> reg 5 unchanged; save asserted during RESTORE -> ignored.
REQ-036 SHALL cover: reset asserted on the 4th SAVE cycle -> all outputs 0 immediately, busy=0, no done pulse.
REQ-037 SHALL cover: ZERO_REG=1 with write 0xFFFF to reg 0 -> r1=0 reads 0; save and restore asserted together -> SAVE is taken.
